// File: rtl/pif_led_ctrl_pkg.sv
// rtl/pif_led_ctrl_pkg.sv - shared register map, LED mode encodings and width helper
package pif_led_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_BRIGHT = 2'd1;
    localparam logic [1:0] ADDR_RATE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_e;

    // Bits needed to hold value (at least one).
    function automatic int bit_width(input longint unsigned value);
        int width;
        width = 1;
        for (int i = 1; i < 64; i++) begin
            if ((value >> i) != 0) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/pif_tick_gen.sv
// rtl/pif_tick_gen.sv - down-counting divider producing a one-cycle Tick every TICK_DIV clocks
module pif_tick_gen
    import pif_led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 177333
) (
    input  logic Clk,
    input  logic Rst,
    output logic Tick
);

    localparam int CNT_W = bit_width(64'(TICK_DIV - 1));
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign Tick = (cnt_q == '0);

endmodule

// File: rtl/pif_led_ctrl.sv
// rtl/pif_led_ctrl.sv - two-LED controller with solid/blink/breathe PWM modes and a small register file
module pif_led_ctrl
    import pif_led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 177333,
    parameter int unsigned PWM_BITS = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       WrEn,
    input  logic       RdEn,
    input  logic [1:0] Addr,
    input  logic [7:0] WrData,
    output logic [7:0] RdData,
    output logic       Ack,
    output logic       red,
    output logic       green
);

    logic                tick;
    logic [3:0]          ctrl_q, ctrl_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [7:0]          rate_q, rate_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0]          blink_cnt_q, blink_cnt_d;
    logic                blink_q, blink_d;
    logic [PWM_BITS:0]   phase_q, phase_d;
    logic                toggle_q, toggle_d;
    logic                ack_q, ack_d;
    logic [7:0]          rd_q, rd_d;
    logic                red_q, red_d;
    logic                green_q, green_d;
    logic [PWM_BITS-1:0] breathe_duty;
    logic [7:0]          rd_val;
    logic                on_bright, on_breathe;

    pif_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .Clk  (Clk),
        .Rst  (Rst),
        .Tick (tick)
    );

    function automatic logic led_on(input led_mode_e mode, input logic blink,
                                    input logic bright_on, input logic breathe_on);
        case (mode)
            MODE_SOLID:   return bright_on;
            MODE_BLINK:   return blink & bright_on;
            MODE_BREATHE: return breathe_on;
            default:      return 1'b0;
        endcase
    endfunction

    // Triangle wave: rising half uses the phase directly, falling half its inverse.
    assign breathe_duty = phase_q[PWM_BITS] ? ~phase_q[PWM_BITS-1:0] : phase_q[PWM_BITS-1:0];
    assign on_bright    = (pwm_cnt_q < bright_q);
    assign on_breathe   = (pwm_cnt_q < breathe_duty);

    always_comb begin
        rd_val = '0;
        case (Addr)
            ADDR_CTRL:   rd_val = {4'b0, ctrl_q};
            ADDR_BRIGHT: rd_val = 8'(bright_q);
            ADDR_RATE:   rd_val = rate_q;
            default:     rd_val = {5'b0, ~green_q, ~red_q, toggle_q};
        endcase
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        bright_d    = bright_q;
        rate_d      = rate_q;
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        phase_d     = tick ? phase_q + (PWM_BITS+1)'(1) : phase_q;
        toggle_d    = toggle_q ^ tick;
        ack_d       = WrEn | RdEn;
        rd_d        = RdEn ? rd_val : 8'h00;
        red_d       = ~led_on(led_mode_e'(ctrl_q[1:0]), blink_q, on_bright, on_breathe);
        green_d     = ~led_on(led_mode_e'(ctrl_q[3:2]), blink_q, on_bright, on_breathe);

        if (WrEn) begin
            case (Addr)
                ADDR_CTRL:   ctrl_d   = WrData[3:0];
                ADDR_BRIGHT: bright_d = WrData[PWM_BITS-1:0];
                ADDR_RATE:   rate_d   = WrData;
                default:     ;
            endcase
        end

        // A RATE write restarts the blink pattern in its on half, overriding a same-cycle Tick.
        if (WrEn && Addr == ADDR_RATE) begin
            blink_cnt_d = 8'd0;
            blink_d     = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == rate_q) begin
                blink_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl_q      <= '0;
            bright_q    <= '0;
            rate_q      <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            phase_q     <= '0;
            toggle_q    <= 1'b0;
            ack_q       <= 1'b0;
            rd_q        <= '0;
            red_q       <= 1'b1;
            green_q     <= 1'b1;
        end else begin
            ctrl_q      <= ctrl_d;
            bright_q    <= bright_d;
            rate_q      <= rate_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            toggle_q    <= toggle_d;
            ack_q       <= ack_d;
            rd_q        <= rd_d;
            red_q       <= red_d;
            green_q     <= green_d;
        end
    end

    assign Ack    = ack_q;
    assign RdData = rd_q;
    assign red    = red_q;
    assign green  = green_q;

endmodule

// File: tb/tb_pif_led_ctrl.sv
// tb/tb_pif_led_ctrl.sv - self-checking bench for pif_led_ctrl with a tick/phase arithmetic reference model
module tb_pif_led_ctrl;

    localparam int TICK_DIV = 8;
    localparam int PWM_BITS = 5;
    localparam int PWM_PER  = 1 << PWM_BITS;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       WrEn;
    logic       RdEn;
    logic [1:0] Addr;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       Ack;
    logic       red;
    logic       green;

    pif_led_ctrl #(.TICK_DIV(TICK_DIV), .PWM_BITS(PWM_BITS)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .WrEn   (WrEn),
        .RdEn   (RdEn),
        .Addr   (Addr),
        .WrData (WrData),
        .RdData (RdData),
        .Ack    (Ack),
        .red    (red),
        .green  (green)
    );

    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: everything derived from elapsed cycles and consumed ticks.
    int   m_k;
    int   m_ticks;
    int   m_anchor;
    int   m_binit;
    int   m_ctrl;
    int   m_bright;
    int   m_rate;
    logic m_red;
    logic m_green;

    typedef struct {
        logic       we;
        logic       re;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_k = 0; m_ticks = 0; m_anchor = 0; m_binit = 0;
        m_ctrl = 0; m_bright = 0; m_rate = 0;
        m_red = 1'b1; m_green = 1'b1;
    endtask

    function automatic int blink_state();
        int t;
        t = m_ticks - m_anchor;
        return m_binit ^ ((t / (m_rate + 1)) % 2);
    endfunction

    function automatic int breathe_duty();
        int ph;
        ph = m_ticks % (2 * PWM_PER);
        return (ph < PWM_PER) ? ph : (2 * PWM_PER - 1) - ph;
    endfunction

    function automatic int led_on(input int mode);
        int pwm;
        pwm = m_k % PWM_PER;
        case (mode)
            0:       return 0;
            1:       return int'(pwm < m_bright);
            2:       return blink_state() & int'(pwm < m_bright);
            default: return int'(pwm < breathe_duty());
        endcase
    endfunction

    function automatic int model_read(input int a);
        case (a)
            0:       return m_ctrl;
            1:       return m_bright;
            2:       return m_rate;
            default: return (int'(!m_green) << 2) | (int'(!m_red) << 1) | (m_ticks % 2);
        endcase
    endfunction

    // One clock: drive strobes, advance the model across the edge, compare just after it.
    task automatic cycle(input logic we, input logic re, input logic [1:0] a, input logic [7:0] d);
        int   exp_rd;
        int   ron;
        int   gon;
        logic tk;
        WrEn = we; RdEn = re; Addr = a; WrData = d;
        exp_rd = re ? model_read(int'(a)) : 0;
        ron = led_on(m_ctrl & 3);
        gon = led_on((m_ctrl >> 2) & 3);
        tk  = ((m_k % TICK_DIV) == 0);
        @(posedge Clk);
        if (we) begin
            case (a)
                2'd0:    m_ctrl   = int'(d) & 15;
                2'd1:    m_bright = int'(d) & (PWM_PER - 1);
                2'd2:    m_rate   = int'(d);
                default: ;
            endcase
        end
        if (tk) m_ticks++;
        if (we && a == 2'd2) begin
            m_anchor = m_ticks;
            m_binit  = 1;
        end
        m_k++;
        m_red   = (ron == 0);
        m_green = (gon == 0);
        #1;
        check("red", int'(red), int'(m_red));
        check("green", int'(green), int'(m_green));
        check("ack", int'(Ack), int'(we | re));
        if (re) check("rddata", int'(RdData), exp_rd);
        WrEn = 1'b0; RdEn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    initial begin
        int         red_low;
        int         green_high;
        int         waited;
        logic       we;
        logic       re;
        logic [1:0] a;
        logic [7:0] d;

        tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'hF5, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h05};
        tbl[2]  = '{1'b1, 1'b0, 2'd1, 8'hFF, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h1F};
        tbl[4]  = '{1'b1, 1'b0, 2'd2, 8'hAB, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'hAB};
        tbl[6]  = '{1'b1, 1'b0, 2'd3, 8'hFF, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h05};
        tbl[8]  = '{1'b1, 1'b0, 2'd1, 8'h05, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 2'd1, 8'h11, 8'h05};
        tbl[10] = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h11};

        Rst = 1'b1; WrEn = 1'b0; RdEn = 1'b0; Addr = 2'd0; WrData = 8'h00;
        #12;
        check("rst_red", int'(red), 1);
        check("rst_green", int'(green), 1);
        check("rst_ack", int'(Ack), 0);
        check("rst_rddata", int'(RdData), 0);
        Rst = 1'b0;
        model_reset();

        // Register map, ignored STATUS write, back-to-back strobes, write+read collision.
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
            if (tbl[i].re) check("tbl_rd", int'(RdData), int'(tbl[i].exp_rd));
        end

        // Solid red at BRIGHT=8: exactly 8 low cycles per 32.
        cycle(1'b1, 1'b0, 2'd0, 8'h01);
        cycle(1'b1, 1'b0, 2'd1, 8'd8);
        idle(3);
        red_low = 0; green_high = 0;
        for (int i = 0; i < PWM_PER; i++) begin
            cycle(1'b0, 1'b0, 2'd0, 8'h00);
            if (red == 1'b0) red_low++;
            if (green == 1'b1) green_high++;
        end
        check("solid_red_low_per_32", red_low, 8);
        check("solid_green_high", green_high, PWM_PER);

        // Green blink, RATE=2, full brightness.
        cycle(1'b1, 1'b0, 2'd2, 8'd2);
        cycle(1'b1, 1'b0, 2'd0, 8'h08);
        cycle(1'b1, 1'b0, 2'd1, 8'd31);
        idle(200);

        // RATE write landing on a Tick.
        waited = 0;
        while ((m_k % TICK_DIV) != 0 && waited < 2 * TICK_DIV) begin
            cycle(1'b0, 1'b0, 2'd0, 8'h00);
            waited++;
        end
        check("tick_align", int'((m_k % TICK_DIV) == 0), 1);
        cycle(1'b1, 1'b0, 2'd2, 8'd1);
        idle(60);

        // Breathe on red through more than one full 64-tick period, including 63->0 wrap.
        cycle(1'b1, 1'b0, 2'd0, 8'h03);
        idle(64 * TICK_DIV + 40);

        // Reset pulse between edges with a write pending and an Ack outstanding.
        cycle(1'b1, 1'b0, 2'd0, 8'h0F);
        WrEn = 1'b1; Addr = 2'd0; WrData = 8'h0A;
        #1 Rst = 1'b1;
        #1;
        check("midrst_red", int'(red), 1);
        check("midrst_green", int'(green), 1);
        check("midrst_ack", int'(Ack), 0);
        check("midrst_rddata", int'(RdData), 0);
        #1 Rst = 1'b0; WrEn = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 2'd0, 8'h00);
        check("ctrl_after_rst", int'(RdData), 0);

        // Randomised register traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 9) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = (a == 2'd2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            cycle(we, re, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pif_led_ctrl.md
PIF_LED_CTRL -- requirements
Module: pif_led_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 177333, Clk cycles per Tick (26.6 MHz / 150 Hz); legal range 2..2^24.
REQ-002 Parameter PWM_BITS, default 5, PWM duty/counter width.
REQ-003 Clk  in  1  single clock domain; all state on rising edge.
REQ-004 Rst  in  1  asynchronous, active-high reset.
REQ-005 WrEn  in  1  one-cycle register write strobe.
REQ-006 RdEn  in  1  one-cycle register read strobe.
REQ-007 Addr  in  2  register address.
REQ-008 WrData  in  8  write data.
REQ-009 RdData  out  8  read data; valid while Ack=1, else 0.
REQ-010 Ack  out  1  one-cycle acknowledge, exactly one cycle after WrEn or RdEn.
REQ-011 red  out  1  red LED drive, active-low.
REQ-012 green  out  1  green LED drive, active-low.

Function
REQ-013 Register map:
- 0 CTRL: [1:0] red mode, [3:2] green mode (0 off, 1 solid, 2 blink, 3 breathe); [7:4] read 0.
- 1 BRIGHT: [PWM_BITS-1:0] solid/blink duty.
- 2 RATE: blink half-period in Ticks minus 1.
- 3 STATUS, read-only: [0] tick toggle, [1] red on, [2] green on.
REQ-014 Writes to address 3 are ignored but still acknowledged.
REQ-015 WrEn and RdEn asserted in the same cycle: the write is performed, RdData returns the pre-write value, and a single Ack is issued.
REQ-016 A strobe arriving while Ack=1 is accepted normally; back-to-back strobes give back-to-back Acks.
REQ-017 Tick divider: down-counter loaded with TICK_DIV-1; Tick pulses for one cycle when the count is 0, then reloads.
REQ-018 PWM counter: free-running PWM_BITS counter advanced every Clk; pwm_on = (pwm_cnt < duty), unsigned compare.
REQ-019 Blink: 8-bit tick counter; when the counter equals RATE on a Tick, the counter clears and blink_state toggles. RATE=0 toggles every Tick.
REQ-020 Breathe: (PWM_BITS+1)-bit phase counter, incremented per Tick, wraps modulo 2^(PWM_BITS+1).
- Breathe duty = phase[PWM_BITS-1:0] when phase MSB=0, else its bitwise inverse (triangle).
REQ-021 Per-LED on-condition:
- off: 0
- solid: pwm_on(BRIGHT)
- blink: blink_state & pwm_on(BRIGHT)
- breathe: pwm_on(breathe duty)
REQ-022 red/green are registered: one Clk after the on-condition is evaluated; pin = !on.
REQ-023 A write to RATE clears the blink counter and sets blink_state=1; this takes priority over a same-cycle Tick.
REQ-024 A write to CTRL or BRIGHT takes effect on the on-condition in the following cycle; no counter is disturbed.
REQ-025 BRIGHT=0 gives an LED that is never on; BRIGHT=2^PWM_BITS-1 gives on for 31 of 32 PWM cycles.

Reset
REQ-026 Rst=1 clears the following asynchronously, independent of Clk:
- CTRL=0, BRIGHT=0, RATE=0
- all counters=0, blink_state=0, tick toggle=0
- Ack=0, RdData=0
- red=1, green=1 (both LEDs off)
REQ-027 Tick divider reloads to TICK_DIV-1 on the first Clk after Rst deasserts.
REQ-028 Rst asserted mid-transaction drops the pending Ack.

Structure
REQ-029 Shared package holds:
- register address constants
- mode encodings (OFF, SOLID, BLINK, BREATHE)
- the bit-width helper function
REQ-030 The tick divider is one sub-module, pif_tick_gen (params TICK_DIV; ports Clk, Rst, Tick); everything else stays in pif_led_ctrl.

Verification (TICK_DIV=8, PWM_BITS=5)
REQ-031 Reset: Rst pulse mid-write with no Clk edge -> red=green=1, Ack=0, and CTRL reads 0 afterwards.
REQ-032 Write CTRL=0x01, BRIGHT=8 -> red low for exactly 8 of every 32 cycles; green stays 1.
REQ-033 Write RATE=2, CTRL=0x08, BRIGHT=31 -> green PWM gated on 3 Ticks (24 cycles), off 3 Ticks, repeating.
REQ-034 CTRL=0x03 -> red duty ramps 0..31 then 31..0 over 64 Ticks and repeats; check wrap at phase 63->0.
REQ-035 Write RATE in the same cycle as Tick -> blink counter=0 and blink_state=1 next cycle.
REQ-036 Simultaneous WrEn/RdEn to address 1 with 0x11 over 0x05 -> Ack once, RdData=0x05, later read returns 0x11.
